alu_muldiv_seq: RTL and testbench

- Multi-cycle sequencer for unsigned 32x32 multiply (MULU) and unsigned divide (DIVU).
- Drives a shared combinational ALU through its A/B/ALUop ports: ADD=3'b010 for shift-add multiply, SUB=3'b110 for restoring divide.
- Sits beside the CPU datapath. Takes requests through a valid/ready handshake and returns a 64-bit {hi,lo} result through a second valid/ready handshake.

---
 rtl/alu_muldiv_seq.sv | 152 +++++++++++++++
 tb/tb_alu_muldiv_seq.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/alu_muldiv_seq.sv
// alu_muldiv_seq -- multi-cycle unsigned multiply / divide sequencer.
//
// Runs a DATA_WIDTH x DATA_WIDTH unsigned multiply (shift-add) or unsigned
// divide (restoring) one bit per cycle. It does not contain an adder of its
// own. Instead it borrows the CPU's combinational ALU through alu_A/alu_B/alu_op
// and samples alu_Result/alu_CarryOut on the same clock edge.
//
// Ports:
//   clk, resetn          clock (rising edge), asynchronous active-low reset
//   req_valid/req_ready  request handshake; req_op 0=MULU 1=DIVU, req_a, req_b
//   cancel               synchronous abort of a BUSY or DONE operation
//   resp_valid/resp_ready response handshake; res_hi/res_lo carry the result
//                        (MULU: product hi/lo, DIVU: remainder/quotient)
//   alu_A, alu_B, alu_op to the shared ALU (ADD=010, SUB=110, idle=000)
//   alu_Result, alu_CarryOut from the shared ALU (SUB carry = borrow, A<B)
//   dbg_state_o          current FSM state (0=IDLE, 1=BUSY, 2=DONE)
//
// Handshakes: a transfer happens on a rising edge where valid and ready are
// both 1. The request side is ready only in IDLE. The response side holds
// resp_valid and the result stable until resp_ready is seen or cancel aborts.

module alu_muldiv_seq #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk,
    input  logic                  resetn,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_op,
    input  logic [DATA_WIDTH-1:0] req_a,
    input  logic [DATA_WIDTH-1:0] req_b,
    input  logic                  cancel,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] res_hi,
    output logic [DATA_WIDTH-1:0] res_lo,
    output logic [DATA_WIDTH-1:0] alu_A,
    output logic [DATA_WIDTH-1:0] alu_B,
    output logic [2:0]            alu_op,
    input  logic [DATA_WIDTH-1:0] alu_Result,
    input  logic                  alu_CarryOut,
    output logic [1:0]            dbg_state_o
);

    localparam int CW = $clog2(DATA_WIDTH) + 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(DATA_WIDTH - 1);
    localparam logic [2:0] ALU_NOP = 3'b000;
    localparam logic [2:0] ALU_ADD = 3'b010;
    localparam logic [2:0] ALU_SUB = 3'b110;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } state_e;

    state_e                state_q, state_d;
    logic [CW-1:0]         cnt_q, cnt_d;
    logic [DATA_WIDTH-1:0] hi_q, hi_d;
    logic [DATA_WIDTH-1:0] lo_q, lo_d;
    logic [DATA_WIDTH-1:0] b_q, b_d;
    logic                  op_q, op_d;

    // Divide step: partial remainder shifted left with the next dividend bit.
    logic [DATA_WIDTH-1:0] div_s;
    logic                  div_take;

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= ST_IDLE;
            cnt_q   <= '0;
            hi_q    <= '0;
            lo_q    <= '0;
            b_q     <= '0;
            op_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            hi_q    <= hi_d;
            lo_q    <= lo_d;
            b_q     <= b_d;
            op_q    <= op_d;
        end
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        hi_d     = hi_q;
        lo_d     = lo_q;
        b_d      = b_q;
        op_d     = op_q;
        alu_A    = '0;
        alu_B    = '0;
        alu_op   = ALU_NOP;
        div_s    = {hi_q[DATA_WIDTH-2:0], lo_q[DATA_WIDTH-1]};
        // The shifted-out hi MSB means s is really DATA_WIDTH+1 bits and
        // therefore certainly >= b, whatever the ALU borrow says.
        div_take = hi_q[DATA_WIDTH-1] | ~alu_CarryOut;

        case (state_q)
            ST_IDLE: begin
                // cancel is ignored here, so a request arriving with it is taken.
                if (req_valid) begin
                    op_d    = req_op;
                    b_d     = req_b;
                    hi_d    = '0;
                    lo_d    = req_a;
                    cnt_d   = '0;
                    state_d = ST_BUSY;
                end
            end
            ST_BUSY: begin
                if (!op_q) begin
                    alu_op = ALU_ADD;
                    alu_A  = hi_q;
                    alu_B  = lo_q[0] ? b_q : '0;
                    // The carry becomes the new hi MSB. The sum LSB shifts into lo.
                    {hi_d, lo_d} = {alu_CarryOut, alu_Result, lo_q[DATA_WIDTH-1:1]};
                end else begin
                    alu_op = ALU_SUB;
                    alu_A  = div_s;
                    alu_B  = b_q;
                    hi_d   = div_take ? alu_Result : div_s;
                    lo_d   = {lo_q[DATA_WIDTH-2:0], div_take};
                end
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d = ST_DONE;
                end
                if (cancel) begin
                    state_d = ST_IDLE;
                end
            end
            ST_DONE: begin
                if (cancel || resp_ready) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign req_ready   = (state_q == ST_IDLE);
    assign resp_valid  = (state_q == ST_DONE);
    assign res_hi      = hi_q;
    assign res_lo      = lo_q;
    assign dbg_state_o = state_q;

endmodule

// File: tb/tb_alu_muldiv_seq.sv
module tb_alu_muldiv_seq;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          resetn;
  logic          req_valid;
  logic          req_ready;
  logic          req_op;
  logic [W-1:0]  req_a;
  logic [W-1:0]  req_b;
  logic          cancel;
  logic          resp_valid;
  logic          resp_ready;
  logic [W-1:0]  res_hi;
  logic [W-1:0]  res_lo;
  logic [W-1:0]  alu_A;
  logic [W-1:0]  alu_B;
  logic [2:0]    alu_op;
  logic [W-1:0]  alu_Result;
  logic          alu_CarryOut;
  logic [1:0]    dbg_state;

  int n_checks = 0;
  int n_errors = 0;
  logic [2*W-1:0] exp_q[$];

  // ---------------- clock / reset block ----------------
  always #5 clk = ~clk;

  // ---------------- DUT + shared ALU -------------------
  alu_muldiv_seq #(.DATA_WIDTH(W)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_op       (req_op),
    .req_a        (req_a),
    .req_b        (req_b),
    .cancel       (cancel),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .res_hi       (res_hi),
    .res_lo       (res_lo),
    .alu_A        (alu_A),
    .alu_B        (alu_B),
    .alu_op       (alu_op),
    .alu_Result   (alu_Result),
    .alu_CarryOut (alu_CarryOut),
    .dbg_state_o  (dbg_state)
  );

  // Combinational CPU ALU the sequencer borrows.
  always_comb begin
    alu_Result   = '0;
    alu_CarryOut = 1'b0;
    case (alu_op)
      3'b010: {alu_CarryOut, alu_Result} = {1'b0, alu_A} + {1'b0, alu_B};
      3'b110: begin
        alu_Result   = alu_A - alu_B;
        alu_CarryOut = (alu_A < alu_B);
      end
      default: ;
    endcase
  end

  // ---------------- reference model --------------------
  function automatic logic [2*W-1:0] ref_result(input logic op, input logic [W-1:0] a,
                                                input logic [W-1:0] b);
    logic [2*W-1:0] r;
    if (!op)
      r = {{W{1'b0}}, a} * {{W{1'b0}}, b};
    else if (b == '0)
      r = {a, {W{1'b1}}};
    else
      r = {a % b, a / b};
    return r;
  endfunction

  // ---------------- checking task ----------------------
  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks -----------------------
  // Called at #1 after a rising edge. Latency counts rising edges from the
  // cycle the request is presented to the first cycle resp_valid is seen.
  task automatic run_op(input logic op, input logic [W-1:0] a, input logic [W-1:0] b,
                        input int hold, input logic with_cancel);
    int edges;
    logic bad_aluop;
    logic [2:0] exp_aluop;
    logic [2*W-1:0] exp;
    exp_aluop = op ? 3'b110 : 3'b010;
    check_eq("req_ready_idle", req_ready, 1);
    check_eq("alu_op_idle", alu_op, 0);
    check_eq("alu_ab_idle", alu_A | alu_B, 0);
    req_valid = 1'b1; req_op = op; req_a = a; req_b = b; cancel = with_cancel;
    @(posedge clk); #1;
    edges = 1;
    req_valid = 1'b0; cancel = 1'b0;
    exp_q.push_back(ref_result(op, a, b));
    check_eq("req_ready_busy", req_ready, 0);
    bad_aluop = 1'b0;
    while (!resp_valid && edges < 200) begin
      if (alu_op !== exp_aluop) bad_aluop = 1'b1;
      @(posedge clk); #1;
      edges++;
    end
    check_eq("alu_op_busy", bad_aluop, 0);
    check_eq("resp_valid_seen", resp_valid, 1);
    if (!resp_valid) begin
      exp_q.delete();
      return;
    end
    check_eq("latency", edges, W + 1);
    exp = exp_q.pop_front();
    for (int i = 0; i < hold; i++) begin
      check_eq("hold_result", {res_hi, res_lo}, exp);
      check_eq("hold_req_ready", req_ready, 0);
      check_eq("hold_resp_valid", resp_valid, 1);
      @(posedge clk); #1;
    end
    check_eq("result", {res_hi, res_lo}, exp);
    resp_ready = 1'b1;
    @(posedge clk); #1;
    resp_ready = 1'b0;
    check_eq("resp_valid_drop", resp_valid, 0);
    check_eq("req_ready_back", req_ready, 1);
  endtask

  task automatic check_reset_values(input string tag);
    check_eq({tag, "_state"}, dbg_state, 0);
    check_eq({tag, "_req_ready"}, req_ready, 1);
    check_eq({tag, "_resp_valid"}, resp_valid, 0);
    check_eq({tag, "_res"}, {res_hi, res_lo}, 0);
    check_eq({tag, "_alu_ab"}, {alu_A, alu_B}, 0);
    check_eq({tag, "_alu_op"}, alu_op, 0);
  endtask

  // ---------------- main sequence ----------------------
  initial begin
    logic seen;
    logic [W-1:0] ra, rb;
    logic rop;
    resetn = 1'b0; req_valid = 1'b0; req_op = 1'b0; req_a = '0; req_b = '0;
    cancel = 1'b0; resp_ready = 1'b0;
    @(posedge clk); #1;
    check_reset_values("reset");
    resetn = 1'b1;
    @(posedge clk); #1;

    // Directed cases
    run_op(1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 1'b0);
    run_op(1'b1, 32'd100, 32'd7, 0, 1'b0);
    run_op(1'b1, 32'hFFFF_FFFF, 32'd1, 0, 1'b0);
    run_op(1'b1, 32'h1234_5678, 32'd0, 0, 1'b0);
    run_op(1'b0, 32'd6, 32'd7, 10, 1'b0);

    // Cancel at BUSY cycle 10: back to IDLE, no response ever
    req_valid = 1'b1; req_op = 1'b0; req_a = 32'd11; req_b = 32'd13;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (9) begin @(posedge clk); #1; end
    cancel = 1'b1;
    @(posedge clk); #1;
    cancel = 1'b0;
    check_eq("cancel_state", dbg_state, 0);
    check_eq("cancel_req_ready", req_ready, 1);
    seen = 1'b0;
    repeat (40) begin
      if (resp_valid) seen = 1'b1;
      @(posedge clk); #1;
    end
    check_eq("cancel_no_resp", seen, 0);
    run_op(1'b0, 32'd3, 32'd5, 0, 1'b0);

    // Cancel together with a request in IDLE is ignored; request is taken
    run_op(1'b1, 32'd1000, 32'd33, 1, 1'b1);

    // Asynchronous reset between edges in the middle of BUSY
    req_valid = 1'b1; req_op = 1'b1; req_a = 32'hDEAD_BEEF; req_b = 32'd5;
    @(posedge clk); #1;
    req_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    #2 resetn = 1'b0;
    #1 check_reset_values("async_reset");
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
    run_op(1'b1, 32'd9, 32'd3, 0, 1'b0);

    // Randomized operations
    for (int n = 0; n < 25; n++) begin
      rop = 1'($urandom_range(0, 1));
      ra = $urandom;
      case ($urandom_range(0, 3))
        0: rb = $urandom;
        1: rb = $urandom_range(1, 255);
        2: rb = '0;
        default: rb = $urandom_range(0, 65535);
      endcase
      if ($urandom_range(0, 3) == 0) ra = $urandom_range(0, 100);
      run_op(rop, ra, rb, $urandom_range(0, 3), 1'b0);
    end

    check_eq("queue_empty", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
